// File: rtl/prores_entropy_pkg.sv
// Shared constants, scan tables and FSM state type for the ProRes AC entropy path.
package prores_entropy_pkg;

    localparam int unsigned COEFF_W    = 20;
    localparam int unsigned BLK_COEFFS = 64;

    // Raster index inside an 8x8 block for each scan position.
    localparam logic [5:0] PROGRESSIVE_SCAN [BLK_COEFFS] = '{
         0,  1,  8,  9,  2,  3, 10, 11,
        16, 17, 24, 25, 18, 19, 26, 27,
         4,  5, 12, 20, 13,  6,  7, 14,
        21, 28, 29, 22, 15, 23, 30, 31,
        32, 33, 40, 48, 41, 34, 35, 42,
        49, 56, 57, 50, 43, 36, 37, 44,
        51, 58, 59, 52, 45, 38, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    localparam logic [5:0] INTERLACED_SCAN [BLK_COEFFS] = '{
         0,  8,  1,  9, 16, 24, 17, 25,
         2, 10,  3, 11, 18, 26, 19, 27,
        32, 40, 33, 34, 41, 48, 56, 49,
        42, 35, 43, 50, 57, 58, 51, 59,
         4, 12,  5,  6, 13, 20, 28, 21,
        14,  7, 15, 22, 29, 36, 44, 37,
        30, 23, 31, 38, 45, 52, 60, 53,
        46, 39, 47, 54, 61, 62, 55, 63
    };

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SCAN,
        DRAIN,
        DONE
    } scan_state_e;

endpackage

// File: rtl/entropy_coeff_skid_buf.sv
// Two-entry valid/ready FIFO holding {last, coefficient} beats ahead of the run/level coder.
module entropy_coeff_skid_buf #(
    parameter int unsigned WIDTH = 21
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    assign push      = in_valid && (count_q != 2'd2);
    assign pop       = out_valid && out_ready;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/entropy_ac_scan_controller.sv
// Streams a slice's AC coefficients (pos 1..63 outer, block inner) into the run/level coder.
// Build option INTERLACED_SCAN_EN adds field_mode to choose the interlaced scan table.
module entropy_ac_scan_controller
    import prores_entropy_pkg::*;
#(
    parameter int unsigned COEFF_W    = prores_entropy_pkg::COEFF_W,
    parameter int unsigned MAX_BLOCKS = 32,
    parameter int unsigned ADDR_W     = 11
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [5:0]         num_blocks,
`ifdef INTERLACED_SCAN_EN
    input  logic               field_mode,
`endif
    output logic               busy,
    output logic               done,
    output logic               enc_init,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [COEFF_W-1:0] rd_data,
    output logic [COEFF_W-1:0] coeff_out,
    output logic               coeff_valid,
    output logic               coeff_last,
    input  logic               out_ready
);

    localparam int unsigned BLK_W = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;

    scan_state_e      state_q;
    logic [5:0]       pos_q;
    logic [BLK_W-1:0] blk_q;
    logic [BLK_W-1:0] n_m1_q;
    logic [BLK_W-1:0] n_m1_start;
    logic             rd_pending_q;
    logic             rd_last_q;
    logic             last_issue;
    logic             pop;
    logic [2:0]       credit_use;
    logic [5:0]       scan_entry;
    logic [1:0]       fifo_count;
    logic [COEFF_W:0] fifo_out;

`ifdef INTERLACED_SCAN_EN
    logic field_q;
    assign scan_entry = field_q ? INTERLACED_SCAN[pos_q] : PROGRESSIVE_SCAN[pos_q];
`else
    assign scan_entry = PROGRESSIVE_SCAN[pos_q];
`endif

    always_comb begin
        if (num_blocks == 6'd0) begin
            n_m1_start = '0;
        end else if (32'(num_blocks) > MAX_BLOCKS) begin
            n_m1_start = BLK_W'(MAX_BLOCKS - 1);
        end else begin
            n_m1_start = BLK_W'(num_blocks - 6'd1);
        end
    end

    // A beat popped this cycle frees its slot in time for data returning next cycle.
    assign pop        = coeff_valid && out_ready;
    assign credit_use = 3'(fifo_count) + 3'(rd_pending_q) - 3'(pop);
    assign rd_en      = (state_q == SCAN) && (credit_use < 3'd2);
    assign last_issue = (pos_q == 6'd63) && (blk_q == n_m1_q);
    assign rd_addr    = rd_en ? (ADDR_W'(blk_q) * ADDR_W'(BLK_COEFFS) + ADDR_W'(scan_entry))
                              : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pos_q        <= 6'd0;
            blk_q        <= '0;
            n_m1_q       <= '0;
            rd_pending_q <= 1'b0;
            rd_last_q    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            enc_init     <= 1'b0;
`ifdef INTERLACED_SCAN_EN
            field_q      <= 1'b0;
`endif
        end else begin
            rd_pending_q <= rd_en;
            rd_last_q    <= rd_en && last_issue;
            enc_init     <= 1'b0;
            done         <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= INIT;
                        n_m1_q   <= n_m1_start;
                        pos_q    <= 6'd1;
                        blk_q    <= '0;
                        busy     <= 1'b1;
                        enc_init <= 1'b1;
`ifdef INTERLACED_SCAN_EN
                        field_q  <= field_mode;
`endif
                    end
                end
                INIT: state_q <= SCAN;
                SCAN: begin
                    if (rd_en) begin
                        if (blk_q == n_m1_q) begin
                            blk_q <= '0;
                            if (pos_q == 6'd63) begin
                                state_q <= DRAIN;
                            end else begin
                                pos_q <= pos_q + 6'd1;
                            end
                        end else begin
                            blk_q <= blk_q + BLK_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (pop && coeff_last) begin
                        state_q <= DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    entropy_coeff_skid_buf #(
        .WIDTH(COEFF_W + 1)
    ) u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (rd_pending_q),
        .in_data  ({rd_last_q, rd_data}),
        .out_valid(coeff_valid),
        .out_data (fifo_out),
        .out_ready(out_ready),
        .count    (fifo_count)
    );

    assign {coeff_last, coeff_out} = fifo_out;

endmodule

// File: tb/tb_entropy_ac_scan_controller.sv
// Scoreboard bench for entropy_ac_scan_controller; honours INTERLACED_SCAN_EN when defined.
module tb_entropy_ac_scan_controller;

    localparam int COEFF_W = 20;
    localparam int ADDR_W  = 11;
    localparam int TIMEOUT = 20000;

    localparam int PROG_TBL [64] = '{
         0,  1,  8,  9,  2,  3, 10, 11, 16, 17, 24, 25, 18, 19, 26, 27,
         4,  5, 12, 20, 13,  6,  7, 14, 21, 28, 29, 22, 15, 23, 30, 31,
        32, 33, 40, 48, 41, 34, 35, 42, 49, 56, 57, 50, 43, 36, 37, 44,
        51, 58, 59, 52, 45, 38, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };
`ifdef INTERLACED_SCAN_EN
    localparam int INTL_TBL [64] = '{
         0,  8,  1,  9, 16, 24, 17, 25,  2, 10,  3, 11, 18, 26, 19, 27,
        32, 40, 33, 34, 41, 48, 56, 49, 42, 35, 43, 50, 57, 58, 51, 59,
         4, 12,  5,  6, 13, 20, 28, 21, 14,  7, 15, 22, 29, 36, 44, 37,
        30, 23, 31, 38, 45, 52, 60, 53, 46, 39, 47, 54, 61, 62, 55, 63
    };
    logic field_mode = 1'b0;
`endif

    logic               clk        = 1'b0;
    logic               reset_n    = 1'b0;
    logic               start      = 1'b0;
    logic [5:0]         num_blocks = 6'd0;
    logic               out_ready  = 1'b1;
    logic [COEFF_W-1:0] rd_data    = '0;
    logic               busy, done, enc_init, rd_en, coeff_valid, coeff_last;
    logic [ADDR_W-1:0]  rd_addr;
    logic [COEFF_W-1:0] coeff_out;

    logic [COEFF_W-1:0] ram [2048];
    logic [COEFF_W:0]   exp_q [$];
    logic [COEFF_W:0]   prev_beat;
    bit                 stall_prev = 0;
    bit                 rand_ready = 0;

    int n_checks = 0, n_fail = 0;
    int cycle = 0, beats = 0, done_cnt = 0, enc_cnt = 0, last_cnt = 0;
    int last_acc_cycle = 0, addr_n = 0, final_val = 0;
    int addr_log [4];
    int beat_log [8];

    entropy_ac_scan_controller u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .num_blocks (num_blocks),
`ifdef INTERLACED_SCAN_EN
        .field_mode (field_mode),
`endif
        .busy       (busy),
        .done       (done),
        .enc_init   (enc_init),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .coeff_out  (coeff_out),
        .coeff_valid(coeff_valid),
        .coeff_last (coeff_last),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    // One-cycle-latency RAM model.
    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
    end

    function automatic logic [COEFF_W-1:0] ram_val(input int a);
        return COEFF_W'((a / 64) * 100 + (a % 64));
    endfunction

    function automatic int scan_of(input int p);
`ifdef INTERLACED_SCAN_EN
        if (field_mode) return INTL_TBL[p];
`endif
        return PROG_TBL[p];
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_expected(input int n);
        for (int p = 1; p < 64; p++) begin
            for (int b = 0; b < n; b++) begin
                exp_q.push_back({(p == 63 && b == n - 1), ram_val(b * 64 + scan_of(p))});
            end
        end
    endtask

    task automatic clear_counts();
        beats = 0; done_cnt = 0; enc_cnt = 0; last_cnt = 0; addr_n = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_enc_init"}, enc_init, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_coeff_out"}, coeff_out, 0);
        check({tag, "_coeff_valid"}, coeff_valid, 0);
        check({tag, "_coeff_last"}, coeff_last, 0);
    endtask

    task automatic run_slice(input int nb, input bit rnd, input bit mid_start);
        int n;
        int cyc;
        n = (nb == 0) ? 1 : (nb > 32) ? 32 : nb;
        push_expected(n);
        clear_counts();
        rand_ready = rnd;
        @(posedge clk); #1;
        num_blocks = 6'(nb);
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        num_blocks = 6'd7;
        cyc = 0;
        while (done_cnt == 0 && cyc < TIMEOUT) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) check("busy_during_slice", busy, 1);
            if (mid_start && cyc == 20) begin
                start      = 1'b1;
                num_blocks = 6'd5;
            end else begin
                start = 1'b0;
            end
        end
        repeat (4) @(posedge clk);
        #1;
        rand_ready = 0;
        check("beat_count", beats, 63 * n);
        check("done_pulses", done_cnt, 1);
        check("enc_init_pulses", enc_cnt, 1);
        check("last_flags", last_cnt, 1);
        check("queue_left", exp_q.size(), 0);
        check("busy_after_done", busy, 0);
        exp_q.delete();
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        cycle++;
        if (!reset_n) begin
            stall_prev = 0;
        end else begin
            if (rd_en && addr_n < 4) begin
                addr_log[addr_n] = int'(rd_addr);
                addr_n++;
            end
            if (enc_init) enc_cnt++;
            if (done) begin
                done_cnt++;
                check("done_after_last", cycle - last_acc_cycle, 1);
            end
            if (stall_prev) begin
                check("stall_valid_held", coeff_valid, 1);
                check("stall_beat_held", {coeff_last, coeff_out}, prev_beat);
            end
            if (coeff_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0d, expected no beat", coeff_out);
                end else begin
                    logic [COEFF_W:0] e;
                    e = exp_q.pop_front();
                    check("beat_data", coeff_out, e[COEFF_W-1:0]);
                    check("beat_last", coeff_last, e[COEFF_W]);
                end
                if (beats < 8) beat_log[beats] = int'(coeff_out);
                final_val = int'(coeff_out);
                if (coeff_last) begin
                    last_cnt++;
                    last_acc_cycle = cycle;
                end
                beats++;
            end
            stall_prev = coeff_valid && !out_ready;
            prev_beat  = {coeff_last, coeff_out};
        end
    end

    initial begin
        int cyc;
        for (int a = 0; a < 2048; a++) ram[a] = ram_val(a);
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset_n = 1'b1;

        run_slice(1, 0, 0);
        check("n1_addr0", addr_log[0], 1);
        check("n1_addr1", addr_log[1], 8);
        check("n1_addr2", addr_log[2], 9);
        check("n1_final", final_val, 63);

        run_slice(4, 0, 0);
        check("n4_beat0", beat_log[0], 1);
        check("n4_beat1", beat_log[1], 101);
        check("n4_beat2", beat_log[2], 201);
        check("n4_beat3", beat_log[3], 301);
        check("n4_beat4", beat_log[4], 8);
        check("n4_beat5", beat_log[5], 108);
        check("n4_final", final_val, 363);

        run_slice(2, 1, 0);
        run_slice(2, 0, 1);
        run_slice(0, 0, 0);
        run_slice(40, 0, 0);

        // Reset in the middle of an N=4 slice.
        push_expected(4);
        clear_counts();
        @(posedge clk); #1;
        num_blocks = 6'd4;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while (beats < 30 && cyc < TIMEOUT) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("beats_before_reset", beats, 30);
        #1;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midreset_no_done", done_cnt, 0);
        run_slice(4, 0, 0);
        check("after_reset_final", final_val, 363);

`ifdef INTERLACED_SCAN_EN
        field_mode = 1'b1;
        run_slice(1, 0, 0);
        check("intl_addr0", addr_log[0], 8);
        check("intl_addr1", addr_log[1], 1);
        field_mode = 1'b0;
        run_slice(1, 0, 0);
        check("prog_addr0", addr_log[0], 1);
        check("prog_addr1", addr_log[1], 8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/entropy_ac_scan_controller.md
Name: entropy_ac_scan_controller

Overview:
Sequences one slice's quantized AC coefficients into the AC run/level entropy coder. Reads the slice coefficient buffer in ProRes AC order: outer loop over scan position 1..63, inner loop over blocks 0..N-1. Presents one coefficient per accepted beat, and re-initialises the run coder at every slice start. Sits between the quantizer output RAM and the run/level coder plus bit packer.

Parameters:
COEFF_W, 20, coefficient width (19-bit data plus 1 headroom bit, two's complement)
MAX_BLOCKS, 32, maximum 8x8 blocks per slice
ADDR_W, 11, coefficient RAM address width; must satisfy 2^ADDR_W >= MAX_BLOCKS*64

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begin a slice
num_blocks  in  6  blocks in the slice; sampled on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last beat is accepted
enc_init  out  1  one-cycle pulse; run coder reloads previousRun=4 and run=0
rd_en  out  1  RAM read strobe
rd_addr  out  ADDR_W  block*64 + scan_tbl[pos]
rd_data  in  COEFF_W  RAM data, valid exactly 1 cycle after rd_en
coeff_out  out  COEFF_W  coefficient to the run/level coder
coeff_valid  out  1  coeff_out valid
coeff_last  out  1  marks the final beat (pos 63, block N-1)
out_ready  in  1  downstream accept; a beat transfers when coeff_valid && out_ready

Behaviour:
- Reset: asynchronous, active-low (reset_n). All outputs reset to 0. FSM resets to IDLE; counters and skid buffer are cleared.
- Slice geometry: num_blocks is latched as N on an accepted start. N=0 is treated as 1. N>MAX_BLOCKS is clamped to MAX_BLOCKS.
- FSM states:
  - IDLE: start accepted -> INIT.
  - INIT (1 cycle): enc_init=1; pos=1, blk=0; busy=1 -> SCAN.
  - SCAN: issue reads; when the last address has been issued -> DRAIN.
  - DRAIN: wait until the skid buffer is empty and the last beat is accepted -> DONE.
  - DONE (1 cycle): done=1, busy=0 -> IDLE.
- Read order: blk increments first; when blk wraps from N-1 to 0, pos increments. The last read is pos=63, blk=N-1. DC (pos 0) is never read.
- Flow control:
  - 2-entry skid FIFO in front of coeff_out.
  - rd_en is issued only when (occupancy + reads in flight) < 2, so no RAM data is ever dropped.
  - With out_ready held at 1, throughput is 1 beat/clk after a 2-cycle initial latency (INIT->first rd_en, then RAM latency).
- Output stability: coeff_out, coeff_valid and coeff_last hold stable while coeff_valid && !out_ready.
- Beat count: exactly 63*N beats per slice; coeff_last is asserted on exactly one of them.
- start while busy: ignored; it does not restart or corrupt the current slice.
- Reset mid-slice: immediate return to IDLE. No done pulse. Pending beats are discarded.
- Data path: coeff_out is rd_data passed through unmodified (signed, COEFF_W bits). No arithmetic is applied.

Optional Feature:
INTERLACED_SCAN_EN:
- Defined: adds input port field_mode (1 bit), latched on an accepted start. field_mode=1 selects the interlaced scan table; 0 selects the progressive table.
- Undefined: no field_mode port; the progressive table is always used.

Decomposition:
- Shared package prores_entropy_pkg:
  - COEFF_W, BLK_COEFFS=64.
  - 64-entry PROGRESSIVE_SCAN and INTERLACED_SCAN constant arrays (6-bit entries).
  - FSM state typedef: IDLE, INIT, SCAN, DRAIN, DONE.
- One sub-module: entropy_coeff_skid_buf (2-entry valid/ready FIFO, COEFF_W+1 bits wide: data plus last). The controller holds the FSM, counters and read-issue logic.

Test Plan:
- N=1, RAM[i]=i, out_ready=1 -> enc_init pulse, then 63 beats. First three rd_addr = 1, 8, 9 (progressive scan[1..3]). coeff_last on beat 63. done exactly 1 cycle after the last acceptance.
- N=4, RAM[b*64+k]=b*100+k -> first beats 1, 101, 201, 301, 8, 108. Total 252 beats. Final beat 363 with coeff_last=1.
- N=2, out_ready toggled pseudo-randomly (about 50%) -> 126 beats in order, none lost or duplicated. Outputs held stable while stalled.
- start pulsed during SCAN of an N=2 slice -> still exactly 126 beats and a single done pulse. num_blocks=0 -> 63 beats. num_blocks=40 -> 2016 beats.
- reset_n asserted at beat 30 of an N=4 slice -> all outputs 0 immediately. A new start then completes a clean 252-beat slice with enc_init pulsed again.
- INTERLACED_SCAN_EN defined, field_mode=1, N=1 -> first rd_addr 8, 1. With field_mode=0, first rd_addr 1, 8.
